data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder for an RV32I data port: a fixed-latency request/response
// handshake in front of a byte-lane word memory with RV32I size/sign handling.
module data_mem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic            reqWrite,
    input  logic [XLEN-1:0] reqAddr,
    input  logic [XLEN-1:0] reqWdata,
    input  logic [2:0]      reqFunct3,
    output logic            respValid,
    input  logic            respReady,
    output logic [XLEN-1:0] respRdata,
    output logic            respErr
);

    localparam int IDXW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, nextState;
    logic [3:0]      count;
    logic            armed;
    logic            latWrite;
    logic [XLEN-1:0] latAddr, latWdata;
    logic [2:0]      latFunct3;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [IDXW-1:0] wordIdx;
    logic [1:0]      lane;
    logic            accept, access, accessErr, commit;
    logic [31:0]     word;
    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;
    logic [XLEN-1:0] loadData;
    logic [3:0]      byteEn;
    logic [31:0]     storeData;

    assign wordIdx = latAddr[IDXW+1:2];
    assign lane    = latAddr[1:0];
    assign accept  = reqValid && reqReady;
    assign access  = (state == WAIT) && (count == 4'd0);
    assign commit  = access && latWrite && !accessErr;

    // armed keeps reqReady low until the first clock edge after reset releases.
    always_comb begin
        nextState = state;
        reqReady  = 1'b0;
        respValid = 1'b0;
        case (state)
            IDLE: begin
                reqReady = armed;
                if (reqValid && armed) nextState = WAIT;
            end
            WAIT: if (count == 4'd0) nextState = RESP;
            RESP: begin
                respValid = 1'b1;
                if (respReady) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        accessErr = |latAddr[XLEN-1:IDXW+2];
        case (latFunct3)
            3'd0:    ;
            3'd1:    if (lane[0]) accessErr = 1'b1;
            3'd2:    if (lane != 2'd0) accessErr = 1'b1;
            3'd4:    if (latWrite) accessErr = 1'b1;
            3'd5:    if (latWrite || lane[0]) accessErr = 1'b1;
            default: accessErr = 1'b1;
        endcase
    end

    always_comb begin
        word     = mem[wordIdx];
        loadByte = word[{lane, 3'b000} +: 8];
        loadHalf = lane[1] ? word[31:16] : word[15:0];
        case (latFunct3)
            3'd0:    loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
            3'd1:    loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
            3'd4:    loadData = XLEN'(loadByte);
            3'd5:    loadData = XLEN'(loadHalf);
            default: loadData = XLEN'(word);
        endcase
    end

    // Store data is replicated across lanes so each enabled lane picks its own byte.
    always_comb begin
        byteEn    = 4'b0000;
        storeData = latWdata[31:0];
        case (latFunct3[1:0])
            2'd0: begin
                byteEn    = 4'b0001 << lane;
                storeData = {4{latWdata[7:0]}};
            end
            2'd1: begin
                byteEn    = lane[1] ? 4'b1100 : 4'b0011;
                storeData = {2{latWdata[15:0]}};
            end
            default: byteEn = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            armed     <= 1'b0;
            latWrite  <= 1'b0;
            latAddr   <= '0;
            latWdata  <= '0;
            latFunct3 <= 3'd0;
            respRdata <= '0;
            respErr   <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= nextState;
            if (accept) begin
                latWrite  <= reqWrite;
                latAddr   <= reqAddr;
                latWdata  <= reqWdata;
                latFunct3 <= reqFunct3;
                count     <= 4'(LATENCY - 1);
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (access) begin
                respErr   <= accessErr;
                respRdata <= (accessErr || latWrite) ? '0 : loadData;
            end else if (state == RESP && respReady) begin
                respErr   <= 1'b0;
                respRdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model predicts each
// response at accept time; an independent monitor checks responses, latency and stalls.
module tb_data_mem_responder;

    localparam int XLEN        = 32;
    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;

    logic        clk = 1'b0, rst = 1'b0;
    logic        reqValid = 1'b0, reqWrite = 1'b0, respReady = 1'b0;
    logic [31:0] reqAddr = '0, reqWdata = '0;
    logic [2:0]  reqFunct3 = '0;
    logic        reqReady, respValid, respErr;
    logic [31:0] respRdata;

    int checks = 0, errors = 0, cyc = 0, stallReq = 0;
    bit inResp = 0, popped = 0;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          size;
        int          acc;
    } exp_t;

    exp_t       q[$];
    exp_t       head;
    logic [7:0] refMem [0:4*DEPTH_WORDS-1];

    data_mem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqWdata(reqWdata), .reqFunct3(reqFunct3),
        .respValid(respValid), .respReady(respReady),
        .respRdata(respRdata), .respErr(respErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, required completion (cycle %0d)", name, cyc);
    endtask

    // Little-endian byte memory; RV32I access rules evaluated directly on byte addresses.
    function automatic void refModel(inout exp_t e);
        e.rdata = '0;
        e.err   = 1'b0;
        e.size  = 1;
        case (e.f3)
            3'd0, 3'd4: e.size = 1;
            3'd1, 3'd5: e.size = 2;
            3'd2:       e.size = 4;
            default:    e.err = 1'b1;
        endcase
        if (e.addr >= 32'(4*DEPTH_WORDS)) e.err = 1'b1;
        if (e.w && e.f3[2]) e.err = 1'b1;
        if (e.addr % e.size != 0) e.err = 1'b1;
        if (!e.err && !e.w) begin
            for (int i = 0; i < e.size; i++) e.rdata |= 32'(refMem[e.addr + i]) << (8*i);
            if (!e.f3[2] && e.size < 4 && e.rdata[8*e.size-1])
                e.rdata |= 32'hFFFF_FFFF << (8*e.size);
        end
    endfunction

    task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        exp_t e;
        int   waited = 0;
        reqWrite  = w;
        reqFunct3 = f3;
        reqAddr   = addr;
        reqWdata  = wdata;
        reqValid  = 1'b1;
        @(negedge clk);
        while (!reqReady && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!reqReady) begin
            reqValid = 1'b0;
            reportTimeout("acceptWait");
            return;
        end
        @(posedge clk);
        #1;
        reqValid  = 1'b0;
        reqWrite  = 1'($urandom);
        reqAddr   = $urandom;
        reqWdata  = $urandom;
        reqFunct3 = 3'($urandom);
        e.w = w; e.f3 = f3; e.addr = addr; e.wdata = wdata; e.acc = cyc;
        refModel(e);
        q.push_back(e);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((q.size() != 0 || inResp) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) reportTimeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        #1;
        checkOutput("resetOutputs", {reqReady, respValid, respErr, respRdata[28:0]}, 32'd0);
        checkOutput("resetRdata", respRdata, 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyBeforeFirstEdge", {31'd0, reqReady}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("readyAfterFirstEdge", {31'd0, reqReady}, 32'd1);
    endtask

    // Monitor: drives respReady (random or stalled) and scores each presented response.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                inResp = 0;
                popped = 0;
            end else begin
                if (popped) begin
                    checkOutput("idleAfterResp", {30'd0, reqReady, respValid}, 32'd2);
                    popped = 0;
                end
                if (respValid) begin
                    if (q.size() == 0) begin
                        checkOutput("unexpectedResp", {31'd0, respValid}, 32'd0);
                    end else begin
                        head = q[0];
                        if (!inResp) begin
                            checkOutput("latency", 32'(cyc - head.acc), 32'(LATENCY));
                            inResp = 1;
                        end
                        checkOutput("rdata", respRdata, head.rdata);
                        checkOutput("err", {31'd0, respErr}, {31'd0, head.err});
                        checkOutput("reqReadyBusy", {31'd0, reqReady}, 32'd0);
                        if (stallReq > 0) begin
                            respReady = 1'b0;
                            stallReq--;
                        end else begin
                            respReady = ($urandom_range(0, 2) != 0);
                        end
                        if (respReady) begin
                            if (head.w && !head.err)
                                for (int i = 0; i < head.size; i++)
                                    refMem[head.addr + i] = head.wdata[8*i +: 8];
                            void'(q.pop_front());
                            inResp = 0;
                            popped = 1;
                        end
                    end
                end else begin
                    respReady = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        #1;
        resetPulse();

        for (int i = 0; i < 32; i++)
            applyStimulus(1'b1, 3'd2, 32'(4*i), (i == 8) ? 32'd0 : $urandom);

        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);
        applyStimulus(1'b1, 3'd0, 32'h11, 32'h000000A5);
        applyStimulus(1'b0, 3'd0, 32'h11, 32'h0);
        applyStimulus(1'b0, 3'd4, 32'h11, 32'h0);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);
        applyStimulus(1'b0, 3'd1, 32'h13, 32'h0);
        applyStimulus(1'b1, 3'd2, 32'h12, 32'h12345678);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);

        waitIdle();
        stallReq = 5;
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);
        waitIdle();

        applyStimulus(1'b1, 3'd2, 32'h20, 32'h11111111);
        #2;
        resetPulse();
        applyStimulus(1'b0, 3'd2, 32'h20, 32'h0);

        applyStimulus(1'b0, 3'd2, 32'(4*DEPTH_WORDS), 32'h0);
        applyStimulus(1'b0, 3'd3, 32'h10, 32'h0);
        applyStimulus(1'b1, 3'd5, 32'h14, 32'hCAFEF00D);

        for (int n = 0; n < 200; n++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = 32'h400 + 32'($urandom_range(0, 4095));
            else addr = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == 3'd2) addr[1:0] = 2'b00;
                else if (f3 == 3'd1 || f3 == 3'd5) addr[0] = 1'b0;
            end
            applyStimulus(w, f3, addr, $urandom);
        end

        waitIdle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
